simon_sound: RTL and testbench

Audio stage of the Simon game, downstream of the game controller. Consumes the controller's lamp code, lamp enable and WIN/LOSE/HS flags and drives a single-bit square-wave speaker output. Plays one tone per lamp while a lamp is lit, a short ascending jingle on win, a double jingle on high score, and a low buzz on lose. Outputs go straight to a top-level `uo_out` pin; no handshake back to the controller beyond an informational BUSY.

---
 rtl/simon_sound_pkg.sv | 71 +++++++
 rtl/simon_sound_tone_gen.sv | 58 +++++
 rtl/simon_sound.sv | 189 ++++++++++++++++++
 tb/tb_simon_sound.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_sound_pkg.sv
// simon_sound_pkg: shared types and constants for the Simon game audio stage.
// Holds the FSM state encoding, tone half-periods (in prescaler ticks),
// the jingle note sequence and the event priority encoder.
package simon_sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAMP   = 2'd1,
    ST_JINGLE = 2'd2,
    ST_BUZZ   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_BUZZ = 2'd1,
    EV_WIN  = 2'd2,
    EV_HS   = 2'd3
  } event_t;

  localparam int HP_W = 14;

  localparam logic [HP_W-1:0] HP_TONE0 = 14'd1515;  // 330 Hz
  localparam logic [HP_W-1:0] HP_TONE1 = 14'd1136;  // 440 Hz
  localparam logic [HP_W-1:0] HP_TONE2 = 14'd902;   // 554 Hz
  localparam logic [HP_W-1:0] HP_TONE3 = 14'd759;   // 659 Hz
  localparam logic [HP_W-1:0] HP_BUZZ  = 14'd11905; // 42 Hz

  // Note sequence, note 0 in the low bits. WIN plays notes 0..3,
  // HS plays the full 0..7 (the win jingle twice).
  localparam logic [15:0] NOTE_SEQ = {2'd3, 2'd2, 2'd1, 2'd0,
                                      2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [2:0] WIN_LAST_NOTE = 3'd3;
  localparam logic [2:0] HS_LAST_NOTE  = 3'd7;
  // The buzz is four NOTE_TICKS-long segments with no phase restart between them.
  localparam logic [2:0] BUZZ_LAST_SEG = 3'd3;

  function automatic logic [HP_W-1:0] tone_half_period(input logic [1:0] tone);
    logic [HP_W-1:0] hp;
    case (tone)
      2'd0:    hp = HP_TONE0;
      2'd1:    hp = HP_TONE1;
      2'd2:    hp = HP_TONE2;
      2'd3:    hp = HP_TONE3;
      default: hp = HP_TONE0;
    endcase
    return hp;
  endfunction

  function automatic logic [1:0] note_tone(input logic [2:0] idx);
    return NOTE_SEQ[{idx, 1'b0} +: 2];
  endfunction

  // LOSE dominates everything; a coincident WIN and HS plays the longer
  // high-score jingle because it already contains the win jingle.
  function automatic event_t event_priority(input logic lose_e,
                                            input logic win_e,
                                            input logic hs_e);
    event_t ev;
    if (lose_e) begin
      ev = EV_BUZZ;
    end else if (hs_e) begin
      ev = EV_HS;
    end else if (win_e) begin
      ev = EV_WIN;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/simon_sound_tone_gen.sv
// simon_sound_tone_gen: square-wave generator. Counts prescaler ticks and
// toggles its level every half_period ticks. restart/disable zero the
// phase; mute only masks the registered output so the phase keeps running.
module simon_sound_tone_gen
  import simon_sound_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [HP_W-1:0] half_period,
  input  logic            restart,
  input  logic            enable,
  input  logic            mute,
  output logic            wave
);

  logic [HP_W-1:0] cnt_r;
  logic [HP_W-1:0] cnt_nxt_s;
  logic            phase_r;
  logic            phase_nxt_s;
  logic            wave_r;

  // Next phase count and level: cleared on restart or disable, stepped per tick.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    phase_nxt_s = phase_r;
    if (!enable || restart) begin
      cnt_nxt_s   = {HP_W{1'b0}};
      phase_nxt_s = 1'b0;
    end else if (tick) begin
      if (cnt_r == half_period - HP_W'(1)) begin
        cnt_nxt_s   = {HP_W{1'b0}};
        phase_nxt_s = ~phase_r;
      end else begin
        cnt_nxt_s = cnt_r + HP_W'(1);
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      phase_nxt_s = phase_r;
    end
  end

  // Phase registers plus the muted, registered speaker level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {HP_W{1'b0}};
      phase_r <= 1'b0;
      wave_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      phase_r <= phase_nxt_s;
      wave_r  <= phase_nxt_s & ~mute;
    end
  end

  assign wave = wave_r;

endmodule

// File: rtl/simon_sound.sv
// simon_sound: audio stage of the Simon game. Edge-detects the controller's
// WIN/LOSE/HS flags, sequences lamp tones, jingles and the lose buzz, and
// drives a single registered speaker bit through simon_sound_tone_gen.
module simon_sound
  import simon_sound_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int NOTE_TICKS = 150_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] lamp,
  input  logic       lamp_ena,
  input  logic       win,
  input  logic       lose,
  input  logic       hs,
  input  logic       mute,
  output logic       speaker,
  output logic       busy
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NOTE_W = $clog2(NOTE_TICKS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_TICKS - 1);

  logic [PRE_W-1:0]  presc_r;
  logic              tick_s;
  logic              win_prev_r, lose_prev_r, hs_prev_r;
  logic              win_edge_s, lose_edge_s, hs_edge_s;
  event_t            evt_s;
  state_t            state_r, state_nxt_s;
  logic [2:0]        note_idx_r, note_idx_nxt_s;
  logic [NOTE_W-1:0] note_cnt_r, note_cnt_nxt_s;
  logic              hs_mode_r, hs_mode_nxt_s;
  logic [1:0]        lamp_cur_r, lamp_cur_nxt_s;
  logic              restart_s;
  logic              note_end_s;
  logic [2:0]        last_note_s;
  logic [HP_W-1:0]   half_period_s;
  logic              busy_r;

  assign tick_s      = (presc_r == PRE_LAST);
  assign win_edge_s  = win  & ~win_prev_r;
  assign lose_edge_s = lose & ~lose_prev_r;
  assign hs_edge_s   = hs   & ~hs_prev_r;
  assign evt_s       = event_priority(lose_edge_s, win_edge_s, hs_edge_s);
  assign note_end_s  = tick_s && (note_cnt_r == NOTE_LAST);
  assign last_note_s = hs_mode_r ? HS_LAST_NOTE : WIN_LAST_NOTE;

  // Free-running tick prescaler; deliberately never resynced to note starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PRE_W{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PRE_W{1'b0}};
    end else begin
      presc_r <= presc_r + PRE_W'(1'b1);
    end
  end

  // Previous-value registers for the WIN/LOSE/HS rising-edge detectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_prev_r  <= 1'b0;
      lose_prev_r <= 1'b0;
      hs_prev_r   <= 1'b0;
    end else begin
      win_prev_r  <= win;
      lose_prev_r <= lose;
      hs_prev_r   <= hs;
    end
  end

  // Next-state decode: event priority, lamp tracking and note/segment stepping.
  always_comb begin
    state_nxt_s    = state_r;
    note_idx_nxt_s = note_idx_r;
    note_cnt_nxt_s = note_cnt_r;
    hs_mode_nxt_s  = hs_mode_r;
    lamp_cur_nxt_s = lamp_cur_r;
    restart_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_LAMP: begin
        if (evt_s == EV_BUZZ) begin
          state_nxt_s    = ST_BUZZ;
          note_idx_nxt_s = 3'd0;
          note_cnt_nxt_s = {NOTE_W{1'b0}};
          restart_s      = 1'b1;
        end else if (evt_s != EV_NONE) begin
          state_nxt_s    = ST_JINGLE;
          hs_mode_nxt_s  = (evt_s == EV_HS);
          note_idx_nxt_s = 3'd0;
          note_cnt_nxt_s = {NOTE_W{1'b0}};
          restart_s      = 1'b1;
        end else if (lamp_ena) begin
          state_nxt_s = ST_LAMP;
          if ((state_r == ST_IDLE) || (lamp != lamp_cur_r)) begin
            lamp_cur_nxt_s = lamp;
            restart_s      = 1'b1;
          end else begin
            restart_s = 1'b0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_JINGLE, ST_BUZZ: begin
        if (lose_edge_s) begin
          // LOSE aborts a jingle, and retriggers a running buzz from its start.
          state_nxt_s    = ST_BUZZ;
          note_idx_nxt_s = 3'd0;
          note_cnt_nxt_s = {NOTE_W{1'b0}};
          restart_s      = 1'b1;
        end else if (note_end_s) begin
          note_cnt_nxt_s = {NOTE_W{1'b0}};
          if (note_idx_r == ((state_r == ST_BUZZ) ? BUZZ_LAST_SEG : last_note_s)) begin
            note_idx_nxt_s = 3'd0;
            restart_s      = 1'b1;
            if (lamp_ena) begin
              state_nxt_s    = ST_LAMP;
              lamp_cur_nxt_s = lamp;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            note_idx_nxt_s = note_idx_r + 3'd1;
            // Buzz segments share one continuous waveform; jingle notes restart.
            restart_s      = (state_r == ST_JINGLE);
          end
        end else if (tick_s) begin
          note_cnt_nxt_s = note_cnt_r + NOTE_W'(1);
        end else begin
          note_cnt_nxt_s = note_cnt_r;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        note_idx_nxt_s = 3'd0;
        note_cnt_nxt_s = {NOTE_W{1'b0}};
        restart_s      = 1'b1;
      end
    endcase
  end

  // Half-period selection for the tone currently being played.
  always_comb begin
    case (state_r)
      ST_IDLE:   half_period_s = HP_TONE0;
      ST_LAMP:   half_period_s = tone_half_period(lamp_cur_r);
      ST_JINGLE: half_period_s = tone_half_period(note_tone(note_idx_r));
      ST_BUZZ:   half_period_s = HP_BUZZ;
      default:   half_period_s = HP_TONE0;
    endcase
  end

  // FSM state, note counters and the registered BUSY flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      note_idx_r <= 3'd0;
      note_cnt_r <= {NOTE_W{1'b0}};
      hs_mode_r  <= 1'b0;
      lamp_cur_r <= 2'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      note_idx_r <= note_idx_nxt_s;
      note_cnt_r <= note_cnt_nxt_s;
      hs_mode_r  <= hs_mode_nxt_s;
      lamp_cur_r <= lamp_cur_nxt_s;
      busy_r     <= (state_nxt_s == ST_JINGLE) || (state_nxt_s == ST_BUZZ);
    end
  end

  simon_sound_tone_gen u_tone_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick_s),
    .half_period (half_period_s),
    .restart     (restart_s),
    .enable      (state_nxt_s != ST_IDLE),
    .mute        (mute),
    .wave        (speaker)
  );

  assign busy = busy_r;

endmodule

// File: tb/tb_simon_sound.sv
// tb_simon_sound: scoreboard bench for simon_sound with CLK_DIV=1.
// The reference model describes playback as time segments (start edge,
// half-period, busy) plus a mute window; the expected speaker level at edge t
// is floor((t-start)/H) mod 2. Every predicted change of (speaker,busy) is
// queued with its edge number; the monitor pops one entry per observed change.
module tb_simon_sound;

  localparam int NT     = 4000;
  localparam int BUZZ_H = 11905;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] lamp = 2'd0;
  logic       lamp_ena = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic       hs = 1'b0;
  logic       mute = 1'b0;
  logic       speaker;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct { int t; bit s; bit b; } ev_t;
  ev_t exp_q[$];
  int  seg_t0[$];
  int  seg_h[$];
  bit  seg_b[$];
  int  mute_t0 = 0;
  int  mute_t1 = 0;
  bit  last_s = 1'b0;
  bit  last_b = 1'b0;
  int  tone_h [4] = '{1515, 1136, 902, 759};

  simon_sound #(.CLK_DIV(1), .NOTE_TICKS(NT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lamp     (lamp),
    .lamp_ena (lamp_ena),
    .win      (win),
    .lose     (lose),
    .hs       (hs),
    .mute     (mute),
    .speaker  (speaker),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic void add_seg(input int t0, input int h, input bit b);
    seg_t0.push_back(t0);
    seg_h.push_back(h);
    seg_b.push_back(b);
  endfunction

  function automatic void exp_at(input int t, output bit s, output bit b);
    int idx;
    idx = -1;
    s = 1'b0;
    b = 1'b0;
    for (int i = 0; i < seg_t0.size(); i++) if (seg_t0[i] <= t) idx = i;
    if (idx >= 0) begin
      b = seg_b[idx];
      if (seg_h[idx] != 0) s = (((t - seg_t0[idx]) / seg_h[idx]) % 2) == 1;
    end
    if (t >= mute_t0 && t < mute_t1) s = 1'b0;
  endfunction

  function automatic void push_range(input int ta, input int tb);
    bit s, b;
    for (int t = ta; t <= tb; t++) begin
      exp_at(t, s, b);
      if (s != last_s || b != last_b) begin
        exp_q.push_back('{t, s, b});
        last_s = s;
        last_b = b;
      end
    end
  endfunction

  // Wait (from a negedge) until the negedge right before posedge number x.
  task automatic at_edge(input int x);
    while (cyc < x - 1) @(negedge clk);
  endtask

  initial begin : monitor
    bit  ps;
    bit  pb;
    ev_t e;
    ps = 1'b0;
    pb = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mon_en) begin
        if (speaker !== ps || busy !== pb) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got spk=%b busy=%b, no change required", cyc, speaker, busy);
          end else begin
            e = exp_q.pop_front();
            if (e.t != cyc || e.s !== speaker || e.b !== busy) begin
              failures++;
              $display("FAIL event cyc=%0d got spk=%b busy=%b, required cyc=%0d spk=%b busy=%b",
                       cyc, speaker, busy, e.t, e.s, e.b);
            end
          end
        end
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missed_event cyc=%0d still spk=%b busy=%b, required at cyc=%0d spk=%b busy=%b",
                   cyc, speaker, busy, e.t, e.s, e.b);
        end
      end
      ps = speaker;
      pb = busy;
    end
  end

  initial begin : stim
    int  e, el, er, l1, l2, d1, d2, k, m0, m1;
    bit  es, eb;
    repeat (2) @(negedge clk);
    checks++;
    if (speaker !== 1'b0) begin failures++; $display("FAIL reset_speaker got %b required 0", speaker); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // Lamp 2 steady tone, then lamp off.
    e = cyc + 5;
    add_seg(e, tone_h[2], 1'b0);
    add_seg(e + 4000, 0, 1'b0);
    push_range(e, e + 4000);
    at_edge(e);        lamp = 2'd2; lamp_ena = 1'b1;
    at_edge(e + 4000); lamp_ena = 1'b0;

    // Random lamp, then a pitch change while lit.
    l1 = $urandom_range(0, 3);
    l2 = (l1 + $urandom_range(1, 3)) % 4;
    d1 = $urandom_range(1000, 2000);
    d2 = $urandom_range(1000, 2000);
    e = cyc + 5;
    add_seg(e, tone_h[l1], 1'b0);
    add_seg(e + d1, tone_h[l2], 1'b0);
    add_seg(e + d1 + d2, 0, 1'b0);
    push_range(e, e + d1 + d2);
    at_edge(e);           lamp = l1[1:0]; lamp_ena = 1'b1;
    at_edge(e + d1);      lamp = l2[1:0];
    at_edge(e + d1 + d2); lamp_ena = 1'b0;

    // Coincident HS and WIN with lamp lit: 8-note jingle, then back to the lamp.
    l1 = $urandom_range(0, 3);
    e = cyc + 5;
    for (int i = 0; i < 8; i++) add_seg(e + i * NT, tone_h[i % 4], 1'b1);
    add_seg(e + 8 * NT, tone_h[l1], 1'b0);
    add_seg(e + 8 * NT + 1000, 0, 1'b0);
    push_range(e, e + 8 * NT + 1000);
    at_edge(e);     win = 1'b1; hs = 1'b1; lamp = l1[1:0]; lamp_ena = 1'b1;
    at_edge(e + 3); win = 1'b0; hs = 1'b0;
    at_edge(e + 8 * NT + 1000); lamp_ena = 1'b0;

    // WIN jingle aborted by LOSE; a WIN edge inside the buzz changes nothing.
    k  = $urandom_range(1000, 4500);
    e  = cyc + 5;
    el = e + k;
    for (int i = 0; i < 4; i++) if (e + i * NT < el) add_seg(e + i * NT, tone_h[i], 1'b1);
    add_seg(el, BUZZ_H, 1'b1);
    add_seg(el + 4 * NT, 0, 1'b0);
    push_range(e, el + 4 * NT);
    at_edge(e);        win = 1'b1;
    at_edge(e + 2);    win = 1'b0;
    at_edge(el);       lose = 1'b1;
    at_edge(el + 3);   lose = 1'b0;
    at_edge(el + 2000); win = 1'b1;
    at_edge(el + 2005); win = 1'b0;
    at_edge(el + 4 * NT + 5);

    // MUTE over part of a lamp tone, released mid-period.
    l1 = $urandom_range(0, 3);
    e  = cyc + 5;
    m0 = e + tone_h[l1] + $urandom_range(1, tone_h[l1] / 2);
    m1 = m0 + $urandom_range(tone_h[l1], 2 * tone_h[l1]);
    mute_t0 = m0;
    mute_t1 = m1;
    add_seg(e, tone_h[l1], 1'b0);
    add_seg(e + 4000, 0, 1'b0);
    push_range(e, e + 4000);
    at_edge(e);        lamp = l1[1:0]; lamp_ena = 1'b1;
    at_edge(m0);       mute = 1'b1;
    at_edge(m1);       mute = 1'b0;
    at_edge(e + 4000); lamp_ena = 1'b0;

    // Asynchronous reset while the buzz is high, then lamp 0 from phase 0.
    e  = cyc + 5;
    er = e + BUZZ_H + $urandom_range(100, 1500);
    add_seg(e, BUZZ_H, 1'b1);
    push_range(e, er - 1);
    at_edge(e);     lose = 1'b1;
    at_edge(e + 3); lose = 1'b0;
    at_edge(er);
    #2;
    exp_at(er - 1, es, eb);
    checks++;
    if (speaker !== es || busy !== eb) begin
      failures++;
      $display("FAIL pre_reset_buzz got spk=%b busy=%b required spk=%b busy=%b", speaker, busy, es, eb);
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (speaker !== 1'b0) begin failures++; $display("FAIL async_reset_speaker got %b required 0", speaker); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got %b required 0", busy); end
    lamp     = 2'd0;
    lamp_ena = 1'b1;
    repeat (3) @(negedge clk);
    seg_t0.delete();
    seg_h.delete();
    seg_b.delete();
    exp_q.delete();
    last_s = 1'b0;
    last_b = 1'b0;
    e = cyc + 1;
    add_seg(e, tone_h[0], 1'b0);
    add_seg(e + 3000, 0, 1'b0);
    push_range(e, e + 3000);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    at_edge(e + 3000); lamp_ena = 1'b0;

    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d left required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
